bcd_countdown: RTL

Loadable multi-digit BCD down-counter with a prescaler and a start/abort/hold control FSM. It decrements a packed BCD value to zero and pulses `done` when it gets there. It is the counterpart to the team's BCD up-counter: it borrows where that counter carries. It drives the reaction timer's random pre-stimulus delay and the countdown display digits.

---
 rtl/bcd_countdown_pkg.sv | 28 ++
 rtl/bcd_countdown_if.sv | 28 ++
 rtl/bcd_digit_dec.sv | 28 ++
 rtl/bcd_countdown.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bcd_countdown_pkg.sv
// Shared definitions for the BCD down-counter.
//   BCD_W / BCD_MAX : width and largest value of one BCD digit
//   state_t         : control FSM encoding (IDLE, RUN)
//   is_valid_bcd    : true when every one of the low `digits` nibbles is <= 9
package bcd_countdown_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The value is passed zero-extended to 64 bits so one function serves
    // any counter width up to 16 digits.
    function automatic logic is_valid_bcd(input logic [63:0] val, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < digits && val[i*BCD_W +: BCD_W] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Control/status bundle of the BCD down-counter.
//   master : drives start, abort, hold, load_val; observes cnt, running, done, load_err
//   slave  : the counter itself
interface bcd_countdown_if #(
    parameter int DIGITS = 4
);
    import bcd_countdown_pkg::*;

    logic                      start;
    logic                      abort;
    logic                      hold;
    logic [BCD_W*DIGITS-1:0]   load_val;
    logic [BCD_W*DIGITS-1:0]   cnt;
    logic                      running;
    logic                      done;
    logic                      load_err;

    modport master (
        output start, abort, hold, load_val,
        input  cnt, running, done, load_err
    );

    modport slave (
        input  start, abort, hold, load_val,
        output cnt, running, done, load_err
    );

endinterface

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrement with borrow chaining.
//   digit_in   : current digit (assumed valid BCD)
//   borrow_in  : request to subtract one from this digit
//   digit_out  : resulting digit
//   borrow_out : this digit was 0 and wrapped to 9, so the next digit owes one
module bcd_digit_dec
    import bcd_countdown_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             borrow_out
);

    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == '0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out = digit_in - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD down-counter with prescaler and start/abort/hold FSM.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of bcd_countdown_if (start/abort/hold/load_val in,
//            cnt/running/done/load_err out, all outputs registered)
// cnt decrements once every TICK_DIV cycles of RUN (not counting hold cycles)
// and done pulses on the edge where it reaches zero.
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic            clk,
    input  logic            reset,
    bcd_countdown_if.slave  bus
);

    localparam int W       = BCD_W * DIGITS;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [W-1:0]        cnt_q, cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                load_err_q, load_err_d;

    // Decremented value of cnt_q, built from a ripple chain of digit cells.
    logic [W-1:0]        cnt_dec;
    logic [DIGITS:0]     borrow;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_dec u_dig (
                .digit_in   (cnt_q[gi*BCD_W +: BCD_W]),
                .borrow_in  (borrow[gi]),
                .digit_out  (cnt_dec[gi*BCD_W +: BCD_W]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    // Final tick: the decrement lands on zero. A borrow out of the top digit
    // would mean cnt was already zero; treat it the same so cnt can never wrap.
    logic at_final;
    assign at_final = (cnt_dec == '0) || borrow[DIGITS];

    logic load_ok;
    assign load_ok = is_valid_bcd(64'(bus.load_val), DIGITS);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        running_d  = running_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // abort is ignored here; start wins if both are high.
                if (bus.start) begin
                    if (!load_ok) begin
                        load_err_d = 1'b1;
                    end else if (bus.load_val == '0) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d     = bus.load_val;
                        presc_d   = '0;
                        running_d = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    running_d = 1'b0;
                    presc_d   = '0;
                end else if (bus.hold) begin
                    // everything frozen
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (at_final) begin
                        cnt_d     = '0;
                        done_d    = 1'b1;
                        running_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                running_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            presc_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule
